// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types plus the memory-stage sequencer state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } memctrl_state_t;

endpackage

// File: rtl/memory_stage_ctrl_link_reg.sv
// LL/SC link register: word address plus valid bit, set by LL, cleared by SC,
// matching local stores and coherence invalidations.
module link_reg (
  input  logic        CLK,
  input  logic        RST,
  input  logic        i_set,
  input  logic        i_clr,
  input  logic [29:0] i_set_word,
  input  logic        i_inv,
  input  logic [29:0] i_inv_word,
  input  logic [29:0] i_cmp_word,
  output logic        o_match
);

  logic        r_valid;
  logic [29:0] r_word;
  logic        w_inv_old;
  logic        w_inv_new;

  assign w_inv_old = i_inv & (i_inv_word == r_word);
  assign w_inv_new = i_inv & (i_inv_word == i_set_word);

  // An invalidate landing on the word being linked this cycle wins over the set.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_valid <= 1'b0;
      r_word  <= '0;
    end else if (i_set) begin
      r_valid <= ~w_inv_new;
      r_word  <= i_set_word;
    end else if (i_clr | w_inv_old) begin
      r_valid <= 1'b0;
    end
  end

  assign o_match = r_valid & (i_cmp_word == r_word);

endmodule

// File: rtl/memory_stage_ctrl.sv
// Memory-stage sequencer: issues dcache requests for the EX/MEM instruction,
// stalls until dhit, strobes the MEM/WB latch and resolves LL/SC.
module memory_stage_ctrl
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  RST,
  input  logic  advance,
  input  logic  mem_ren,
  input  logic  mem_wen,
  input  logic  mem_atomic,
  input  word_t mem_addr,
  input  word_t mem_store,
  input  logic  dhit,
  input  word_t dload,
  input  logic  ccinv,
  input  word_t ccsnoopaddr,
  output logic  dmemREN,
  output logic  dmemWEN,
  output word_t dmemaddr,
  output word_t dmemstore,
  output logic  latch_en,
  output logic  stall,
  output word_t mem_dload,
  output logic  datomic
);

  memctrl_state_t r_state;
  logic           r_done;
  word_t          r_hold;

  logic  w_is_sc;
  logic  w_memop;
  logic  w_link_match;
  logic  w_sc_fail;
  logic  w_req;
  logic  w_hit;
  word_t w_load_val;
  logic  w_ren;
  logic  w_wen;
  logic  w_atomic;
  logic  w_latch;
  logic  w_stall;
  word_t w_dload;
  logic  w_unused_lsb;

  assign w_unused_lsb = ^ccsnoopaddr[1:0];

  assign w_is_sc = mem_wen & mem_atomic;
  assign w_memop = mem_ren | mem_wen;
  // SC success is decided at issue; once in WAIT the write is committed to the cache.
  assign w_sc_fail  = (r_state == IDLE) & w_is_sc & ~w_link_match;
  assign w_req      = w_memop & ~w_sc_fail & ~r_done;
  assign w_hit      = w_req & dhit;
  assign w_load_val = w_is_sc ? {31'd0, w_hit} : dload;

  always_comb begin
    w_ren    = w_req & mem_ren;
    w_wen    = w_req & mem_wen;
    w_atomic = w_req & mem_atomic;
    w_latch  = 1'b0;
    w_stall  = 1'b0;
    w_dload  = w_load_val;
    if (r_done) begin
      w_latch = advance;
      w_dload = r_hold;
    end else if (w_req) begin
      w_stall = ~dhit;
      w_latch = dhit & advance;
    end else begin
      w_latch = advance;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
      r_hold  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req & ~dhit) r_state <= WAIT;
        end
        WAIT: begin
          if (r_done) begin
            if (advance) begin
              r_state <= IDLE;
              r_done  <= 1'b0;
            end
          end else if (w_hit) begin
            if (advance) begin
              r_state <= IDLE;
            end else begin
              r_done <= 1'b1;
              r_hold <= w_load_val;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  link_reg u_link (
    .CLK        (CLK),
    .RST        (RST),
    .i_set      (w_hit & mem_ren & mem_atomic),
    .i_clr      (w_hit & mem_wen & (mem_atomic | w_link_match)),
    .i_set_word (mem_addr[31:2]),
    .i_inv      (ccinv),
    .i_inv_word (ccsnoopaddr[31:2]),
    .i_cmp_word (mem_addr[31:2]),
    .o_match    (w_link_match)
  );

  // Outputs are forced low for the whole reset window, including mid-request.
  assign dmemREN   = w_ren & ~RST;
  assign dmemWEN   = w_wen & ~RST;
  assign datomic   = w_atomic & ~RST;
  assign latch_en  = w_latch & ~RST;
  assign stall     = w_stall & ~RST;
  assign dmemaddr  = (RST | ~w_req) ? '0 : mem_addr;
  assign dmemstore = (RST | ~w_wen) ? '0 : mem_store;
  assign mem_dload = RST ? '0 : w_dload;

endmodule

// File: tb/tb_memory_stage_ctrl.sv
// Self-checking bench for memory_stage_ctrl: vector table, directed multi-cycle
// sequences and randomized transactions against a transaction-level model.
module tb_memory_stage_ctrl;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  RST;
  logic  advance, mem_ren, mem_wen, mem_atomic, dhit, ccinv;
  word_t mem_addr, mem_store, dload, ccsnoopaddr;
  logic  dmemREN, dmemWEN, latch_en, stall, datomic;
  word_t dmemaddr, dmemstore, mem_dload;

  int n_checks = 0;
  int n_errors = 0;

  memory_stage_ctrl dut (
    .CLK(CLK), .RST(RST), .advance(advance), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_atomic(mem_atomic), .mem_addr(mem_addr), .mem_store(mem_store), .dhit(dhit),
    .dload(dload), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr), .dmemREN(dmemREN),
    .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore), .latch_en(latch_en),
    .stall(stall), .mem_dload(mem_dload), .datomic(datomic)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ctl = {ren, wen, atomic, advance, dhit}; exp = {REN, WEN, latch_en, stall, datomic}
  typedef struct {
    logic [4:0] ctl;
    word_t      addr;
    word_t      store;
    word_t      dl;
    logic       inv;
    word_t      snoop;
    logic [4:0] exp;
    logic       chk;
    word_t      edl;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [4:0] ctl, input word_t addr, input word_t store,
                              input word_t dl, input logic inv, input word_t snoop,
                              input logic [4:0] ex, input logic chk, input word_t edl);
    vec_t r;
    r.ctl = ctl; r.addr = addr; r.store = store; r.dl = dl; r.inv = inv;
    r.snoop = snoop; r.exp = ex; r.chk = chk; r.edl = edl;
    return r;
  endfunction

  function automatic logic [4:0] outs();
    return {dmemREN, dmemWEN, latch_en, stall, datomic};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] ctl, input word_t addr, input word_t store,
                       input word_t dl, input logic inv, input word_t snoop);
    {mem_ren, mem_wen, mem_atomic, advance, dhit} = ctl;
    mem_addr = addr; mem_store = store; dload = dl; ccinv = inv; ccsnoopaddr = snoop;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // transaction-level model state
  logic        m_valid;
  logic [29:0] m_word;

  initial begin
    int          stall_cnt, req_cnt, latch_cnt, latch_cyc, bad;
    word_t       latch_val, hit_val, addr, store, snoop;
    int          op, d, a;
    logic        adv, inv, sc_ok;
    logic [1:0]  kind;

    RST = 1'b1;
    drive(5'b00010, 32'h100, 32'h0, 32'hFFFF_FFFF, 1'b0, 32'h0);
    #3;
    check("reset outs", {27'd0, outs()}, 32'd0);
    check("reset data", mem_dload | dmemaddr | dmemstore, 32'd0);
    next_cycle();
    RST = 1'b0;

    // ---------------- table-driven vectors ----------------
    vecs.push_back(mk(5'b00010, 32'h000, 32'h0, 32'h0,        1'b0, 32'h0,   5'b00100, 1'b0, 32'h0));
    vecs.push_back(mk(5'b00000, 32'h000, 32'h0, 32'h0,        1'b0, 32'h0,   5'b00000, 1'b0, 32'h0));
    vecs.push_back(mk(5'b10011, 32'h100, 32'h0, 32'h1111_2222, 1'b0, 32'h0,  5'b10100, 1'b1, 32'h1111_2222));
    vecs.push_back(mk(5'b01011, 32'h104, 32'hABCD, 32'h0,     1'b0, 32'h0,   5'b01100, 1'b0, 32'h0));
    vecs.push_back(mk(5'b01110, 32'h200, 32'h5, 32'h99,       1'b0, 32'h0,   5'b00100, 1'b1, 32'h0));
    vecs.push_back(mk(5'b10111, 32'h200, 32'h0, 32'hCAFE_0000, 1'b0, 32'h0,  5'b10101, 1'b1, 32'hCAFE_0000));
    vecs.push_back(mk(5'b01111, 32'h200, 32'h5, 32'h77,       1'b0, 32'h0,   5'b01101, 1'b1, 32'h1));
    vecs.push_back(mk(5'b01110, 32'h200, 32'h5, 32'h77,       1'b0, 32'h0,   5'b00100, 1'b1, 32'h0));
    vecs.push_back(mk(5'b10010, 32'h300, 32'h0, 32'h55,       1'b0, 32'h0,   5'b10010, 1'b0, 32'h0));
    vecs.push_back(mk(5'b10011, 32'h300, 32'h0, 32'h3333,     1'b0, 32'h0,   5'b10100, 1'b1, 32'h3333));
    vecs.push_back(mk(5'b10111, 32'h208, 32'h0, 32'h77,       1'b0, 32'h0,   5'b10101, 1'b1, 32'h77));
    vecs.push_back(mk(5'b00010, 32'h000, 32'h0, 32'h0,        1'b1, 32'h20C, 5'b00100, 1'b0, 32'h0));
    vecs.push_back(mk(5'b01111, 32'h208, 32'h9, 32'h0,        1'b0, 32'h0,   5'b01101, 1'b1, 32'h1));
    vecs.push_back(mk(5'b10111, 32'h400, 32'h0, 32'h44,       1'b1, 32'h400, 5'b10101, 1'b1, 32'h44));
    vecs.push_back(mk(5'b01110, 32'h400, 32'h1, 32'h0,        1'b0, 32'h0,   5'b00100, 1'b1, 32'h0));
    vecs.push_back(mk(5'b10111, 32'h500, 32'h0, 32'h50,       1'b0, 32'h0,   5'b10101, 1'b1, 32'h50));
    vecs.push_back(mk(5'b01011, 32'h500, 32'h2, 32'h0,        1'b0, 32'h0,   5'b01100, 1'b0, 32'h0));
    vecs.push_back(mk(5'b01110, 32'h500, 32'h3, 32'h0,        1'b0, 32'h0,   5'b00100, 1'b1, 32'h0));
    vecs.push_back(mk(5'b10111, 32'h600, 32'h0, 32'h60,       1'b0, 32'h0,   5'b10101, 1'b1, 32'h60));
    vecs.push_back(mk(5'b01011, 32'h604, 32'h4, 32'h0,        1'b0, 32'h0,   5'b01100, 1'b0, 32'h0));
    vecs.push_back(mk(5'b01111, 32'h600, 32'h6, 32'h0,        1'b0, 32'h0,   5'b01101, 1'b1, 32'h1));
    vecs.push_back(mk(5'b10111, 32'h700, 32'h0, 32'h70,       1'b0, 32'h0,   5'b10101, 1'b1, 32'h70));
    vecs.push_back(mk(5'b01111, 32'h703, 32'h7, 32'h0,        1'b0, 32'h0,   5'b01101, 1'b1, 32'h1));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ctl, vecs[i].addr, vecs[i].store, vecs[i].dl, vecs[i].inv, vecs[i].snoop);
      @(negedge CLK);
      check($sformatf("vec%0d outs", i), {27'd0, outs()}, {27'd0, vecs[i].exp});
      if (vecs[i].exp[4] | vecs[i].exp[3])
        check($sformatf("vec%0d addr", i), dmemaddr, vecs[i].addr);
      if (vecs[i].exp[3])
        check($sformatf("vec%0d store", i), dmemstore, vecs[i].store);
      if (vecs[i].chk)
        check($sformatf("vec%0d dload", i), mem_dload, vecs[i].edl);
      next_cycle();
    end

    // ---------------- LW 0x100, dhit on 3rd cycle ----------------
    stall_cnt = 0; latch_cnt = 0; latch_val = 32'h0;
    for (int c = 0; c < 3; c++) begin
      drive({4'b1001, c == 2}, 32'h100, 32'h0, (c == 2) ? 32'hDEAD_BEEF : 32'h0BAD_0000, 1'b0, 32'h0);
      @(negedge CLK);
      if (stall) stall_cnt++;
      if (latch_en) begin latch_cnt++; latch_val = mem_dload; end
      next_cycle();
    end
    check("lw_miss stalls", stall_cnt, 2);
    check("lw_miss latch pulses", latch_cnt, 1);
    check("lw_miss data", latch_val, 32'hDEAD_BEEF);

    // ---------------- hit while advance low, held data ----------------
    drive(5'b10010, 32'h180, 32'h0, 32'h0, 1'b0, 32'h0);
    next_cycle();
    drive(5'b10001, 32'h180, 32'h0, 32'h1234_5678, 1'b0, 32'h0);
    @(negedge CLK);
    check("hold hit outs", {27'd0, outs()}, {27'd0, 5'b10000});
    next_cycle();
    for (int c = 0; c < 2; c++) begin
      drive(5'b10000, 32'h180, 32'h0, 32'hFFFF_0000 + c, 1'b0, 32'h0);
      @(negedge CLK);
      check($sformatf("hold wait%0d outs", c), {27'd0, outs()}, 32'd0);
      next_cycle();
    end
    drive(5'b10010, 32'h180, 32'h0, 32'hAAAA_AAAA, 1'b0, 32'h0);
    @(negedge CLK);
    check("hold release outs", {27'd0, outs()}, {27'd0, 5'b00100});
    check("hold release data", mem_dload, 32'h1234_5678);
    next_cycle();
    drive(5'b00010, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    @(negedge CLK);
    check("hold back idle", {27'd0, outs()}, {27'd0, 5'b00100});
    next_cycle();

    // ---------------- reset during WAIT ----------------
    drive(5'b10111, 32'h800, 32'h0, 32'h8, 1'b0, 32'h0);
    next_cycle();
    drive(5'b10010, 32'h900, 32'h0, 32'h9, 1'b0, 32'h0);
    next_cycle();
    @(negedge CLK);
    check("wait stall before rst", {31'd0, stall}, 32'd1);
    RST = 1'b1;
    #1;
    check("rst wait outs", {27'd0, outs()}, 32'd0);
    check("rst wait data", mem_dload | dmemaddr | dmemstore, 32'd0);
    next_cycle();
    RST = 1'b0;
    drive(5'b00010, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    @(negedge CLK);
    check("post rst idle", {27'd0, outs()}, {27'd0, 5'b00100});
    next_cycle();
    drive(5'b01111, 32'h800, 32'h5, 32'h0, 1'b0, 32'h0);
    @(negedge CLK);
    check("post rst sc outs", {27'd0, outs()}, {27'd0, 5'b00100});
    check("post rst sc data", mem_dload, 32'd0);
    next_cycle();

    // ---------------- randomized transactions ----------------
    m_valid = 1'b0;
    m_word  = '0;
    for (int t = 0; t < 300; t++) begin
      op    = int'($urandom_range(0, 4));
      addr  = 32'h1000 + 32'($urandom_range(0, 3) * 4 + $urandom_range(0, 3));
      store = $urandom;
      if (op == 0) begin
        inv   = 1'($urandom_range(0, 1));
        snoop = 32'h1000 + 32'($urandom_range(0, 3) * 4 + $urandom_range(0, 3));
        drive(5'b00010, addr, store, $urandom, inv, snoop);
        @(negedge CLK);
        check($sformatf("rnd%0d nop", t), {27'd0, outs()}, {27'd0, 5'b00100});
        if (inv && snoop[31:2] == m_word) m_valid = 1'b0;
        next_cycle();
        continue;
      end
      sc_ok = m_valid && (addr[31:2] == m_word);
      if (op == 4 && !sc_ok) begin
        drive({4'b0111, 1'($urandom_range(0, 1))}, addr, store, $urandom, 1'b0, 32'h0);
        @(negedge CLK);
        check($sformatf("rnd%0d scfail outs", t), {27'd0, outs()}, {27'd0, 5'b00100});
        check($sformatf("rnd%0d scfail data", t), mem_dload, 32'd0);
        next_cycle();
        continue;
      end
      d    = int'($urandom_range(0, 3));
      a    = (d == 0) ? 0 : int'($urandom_range(0, 2));
      kind = (op == 1 || op == 3) ? 2'b10 : 2'b01;
      stall_cnt = 0; req_cnt = 0; latch_cnt = 0; latch_cyc = -1; bad = 0;
      latch_val = 32'h0; hit_val = 32'h0;
      for (int c = 0; c <= d + a; c++) begin
        if (c < d)       adv = 1'($urandom_range(0, 1));
        else if (c == d) adv = (a == 0);
        else             adv = (c == d + a);
        dload = $urandom;
        if (c == d) hit_val = dload;
        drive({kind[1], kind[0], (op >= 3), adv, (c == d)}, addr, store, dload, 1'b0, 32'h0);
        @(negedge CLK);
        if (stall) stall_cnt++;
        if (dmemREN | dmemWEN) begin
          req_cnt++;
          if ({dmemREN, dmemWEN} !== kind || dmemaddr !== addr) bad++;
          if (dmemWEN && dmemstore !== store) bad++;
        end
        if (latch_en) begin latch_cnt++; latch_cyc = c; latch_val = mem_dload; end
        next_cycle();
      end
      check($sformatf("rnd%0d stalls", t), stall_cnt, d);
      check($sformatf("rnd%0d requests", t), req_cnt, d + 1);
      check($sformatf("rnd%0d bad requests", t), bad, 0);
      check($sformatf("rnd%0d latch pulses", t), latch_cnt, 1);
      check($sformatf("rnd%0d latch cycle", t), latch_cyc, d + a);
      if (op == 1 || op == 3) check($sformatf("rnd%0d load data", t), latch_val, hit_val);
      if (op == 4)            check($sformatf("rnd%0d sc data", t), latch_val, 32'd1);
      if (op == 3) begin
        m_valid = 1'b1;
        m_word  = addr[31:2];
      end else if (op == 4) begin
        m_valid = 1'b0;
      end else if (op == 2 && addr[31:2] == m_word) begin
        m_valid = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
